pipe_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage.sv | 49 ++++
 rtl/pipe_reg.sv | 100 ++++++++++
 tb/tb_pipe_reg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared sizing helpers for the elastic register pipeline.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Occupancy counter width: enough bits to hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: payload register plus valid bit with load, flush and async reset.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                 WIDTH_P     = DEFAULT_WIDTH,
  parameter logic [WIDTH_P-1:0] RESET_VAL_P = '0
) (
  input  logic               clk,
  input  logic               reset_ni,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [WIDTH_P-1:0] data_i,
  output logic               valid_o,
  output logic [WIDTH_P-1:0] data_o
);

  logic               valid_q, valid_d;
  logic [WIDTH_P-1:0] data_q,  data_d;

  // The payload only moves with a valid word; an empty load just clears the valid bit.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL_P;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL_P;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg.sv
// Elastic multi-stage register pipeline with valid/ready flow control, flush and occupancy count.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int                 WIDTH_P     = DEFAULT_WIDTH,
  parameter int                 DEPTH_P     = 2,
  parameter logic [WIDTH_P-1:0] RESET_VAL_P = '0
) (
  input  logic                         clk,
  input  logic                         reset_ni,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [WIDTH_P-1:0]           data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [WIDTH_P-1:0]           data_o,
  output logic [occ_w(DEPTH_P)-1:0]    occupancy_o
);

  localparam int               OCC_W   = occ_w(DEPTH_P);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  if (DEPTH_P < 1) begin : g_bad_depth
    $error("pipe_reg: DEPTH_P must be at least 1");
  end

  logic [DEPTH_P-1:0] stage_vld;
  logic [WIDTH_P-1:0] stage_data [DEPTH_P];
  logic [DEPTH_P:0]   acc;
  logic               in_fire;
  logic               out_fire;
  logic [OCC_W-1:0]   occ_q, occ_d;

  // A stage can take a word if it is empty or its occupant moves on this edge.
  always_comb begin
    acc          = '0;
    acc[DEPTH_P] = ready_i;
    for (int k = DEPTH_P - 1; k >= 0; k--) begin
      acc[k] = !stage_vld[k] || acc[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH_P; k++) begin : g_stage
    logic               vld_in;
    logic [WIDTH_P-1:0] data_in;

    if (k == 0) begin : g_head
      assign vld_in  = valid_i;
      assign data_in = data_i;
    end else begin : g_body
      assign vld_in  = stage_vld[k-1];
      assign data_in = stage_data[k-1];
    end

    pipe_stage #(
      .WIDTH_P     (WIDTH_P),
      .RESET_VAL_P (RESET_VAL_P)
    ) u_stage (
      .clk      (clk),
      .reset_ni (reset_ni),
      .load_i   (en_i && acc[k] && !flush_i),
      .flush_i  (flush_i),
      .valid_i  (vld_in),
      .data_i   (data_in),
      .valid_o  (stage_vld[k]),
      .data_o   (stage_data[k])
    );
  end

  assign ready_o  = flush_i || (en_i && acc[0]);
  assign valid_o  = en_i && stage_vld[DEPTH_P-1];
  assign data_o   = stage_data[DEPTH_P-1];
  assign in_fire  = en_i && valid_i && acc[0] && !flush_i;
  assign out_fire = valid_o && ready_i && !flush_i;

  // Simultaneous in and out cancel, so the count tracks the number of valid stages.
  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_ONE;
    end else if (out_fire && !in_fire) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg: accepted words are queued, a monitor pops them on output transfers.
module tb_pipe_reg;

  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_ni, en_i, flush_i, valid_i, ready_i;
  logic       ready_o, valid_o;
  logic [7:0] data_i, data_o;
  logic [1:0] occupancy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit lat_mode = 1'b0;

  typedef struct {
    logic [7:0] d;
    int         c;
    bit         lat;
  } exp_t;

  exp_t q[$];

  pipe_reg #(
    .WIDTH_P     (W),
    .DEPTH_P     (D),
    .RESET_VAL_P (RV)
  ) dut (
    .clk         (clk),
    .reset_ni    (reset_ni),
    .en_i        (en_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .occupancy_o (occupancy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Records an accepted word, then advances to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (reset_ni && en_i && valid_i && ready_o && !flush_i)
      q.push_back('{data_i, cyc, lat_mode});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    valid_i = 1'b1;
    data_i  = d;
    step();
    valid_i = 1'b0;
  endtask

  // Monitor: every output transfer must match the oldest accepted word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_ni && valid_o && ready_i && !flush_i) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h expected no output", data_o);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(data_o), 32'(e.d));
          if (e.lat) chk("latency", cyc - e.c, 3);
        end
      end
    end
  end

  initial begin
    reset_ni = 1'b1;
    en_i     = 1'b1;
    flush_i  = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    data_i   = 8'h00;

    // 1: asynchronous reset mid-cycle, then idle
    #12;
    reset_ni = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_data", 32'(data_o), 32'hA5);
    chk("rst_occ", 32'(occupancy_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    #1;
    chk("idle_ready", 32'(ready_o), 1);
    chk("idle_valid", 32'(valid_o), 0);

    // 2: back-to-back streaming, fixed three-cycle latency
    lat_mode = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(i);
      step();
    end
    valid_i  = 1'b0;
    lat_mode = 1'b0;
    chk("stream_occ", 32'(occupancy_o), 3);
    chk("stream_full_ready", 32'(ready_o), 1);
    repeat (4) step();
    chk("stream_drain_occ", 32'(occupancy_o), 0);
    chk("stream_q_empty", q.size(), 0);

    // 3: backpressure fills the pipe and blocks a fourth word
    ready_i = 1'b0;
    send(8'h10);
    send(8'h11);
    send(8'h12);
    chk("bp_occ", 32'(occupancy_o), 3);
    valid_i = 1'b1;
    data_i  = 8'h13;
    #1;
    chk("bp_ready", 32'(ready_o), 0);
    chk("bp_data_head", 32'(data_o), 32'h10);
    step();
    valid_i = 1'b0;
    chk("bp_occ_hold", 32'(occupancy_o), 3);
    ready_i = 1'b1;
    repeat (4) step();
    chk("bp_q_empty", q.size(), 0);
    chk("bp_occ_end", 32'(occupancy_o), 0);

    // 4: bubble collapse under stall
    ready_i = 1'b0;
    send(8'h20);
    step();
    send(8'h21);
    step();
    step();
    chk("bub_occ", 32'(occupancy_o), 2);
    chk("bub_valid", 32'(valid_o), 1);
    chk("bub_data", 32'(data_o), 32'h20);
    chk("bub_ready", 32'(ready_o), 1);
    ready_i = 1'b1;
    step();
    chk("bub_adjacent_valid", 32'(valid_o), 1);
    chk("bub_adjacent_data", 32'(data_o), 32'h21);
    step();
    chk("bub_q_empty", q.size(), 0);

    // 5: flush on a full pipe drops everything, including the word offered that cycle
    ready_i = 1'b0;
    send(8'h30);
    send(8'h31);
    send(8'h32);
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h55;
    #1;
    chk("flush_ready", 32'(ready_o), 1);
    step();
    q.delete();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_valid", 32'(valid_o), 0);
    chk("flush_data", 32'(data_o), 32'hA5);
    chk("flush_occ", 32'(occupancy_o), 0);
    ready_i = 1'b1;
    repeat (3) step();
    chk("flush_no_output", 32'(valid_o), 0);

    // 6: enable low freezes a full pipe
    ready_i = 1'b0;
    send(8'h40);
    send(8'h41);
    send(8'h42);
    ready_i = 1'b1;
    en_i    = 1'b0;
    #1;
    chk("en0_valid", 32'(valid_o), 0);
    chk("en0_ready", 32'(ready_o), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en0_occ", 32'(occupancy_o), 3);
      chk("en0_data", 32'(data_o), 32'h40);
    end
    en_i = 1'b1;
    repeat (4) step();
    chk("en0_q_empty", q.size(), 0);

    // 7: reset mid-stream discards in-flight words
    ready_i = 1'b0;
    send(8'h60);
    send(8'h61);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_data", 32'(data_o), 32'hA5);
    chk("mid_rst_occ", 32'(occupancy_o), 0);
    q.delete();
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    ready_i  = 1'b1;
    repeat (3) step();
    chk("mid_rst_no_output", 32'(valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
